// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a multi-step ALU: IDLE -> EXEC [-> SHIFT] -> WB.
// Define ALU_SEQ_STALL_EN to add a stall input that freezes the sequence.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
`ifdef ALU_SEQ_STALL_EN
  input  logic        stall,
`endif
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  output logic        req_ready,
  output logic [1:0]  alusrc,
  output logic        alu_en,
  output logic        shift_en,
  output logic        result_we,
  output logic        err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, WB} state_t;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_LUI = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;
  localparam logic [1:0] SRC_K16 = 2'b10;

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic       stall_i;
  logic       accept;

`ifdef ALU_SEQ_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign accept = req_valid && req_ready;

  // All datapath controls decode from state and latched op, never from req_valid.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    alusrc    = SRC_REG;
    alu_en    = 1'b0;
    shift_en  = 1'b0;
    result_we = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !stall_i;
        if (req_valid && !stall_i && (req_op != OP_ILL))
          state_nxt = EXEC;
      end
      EXEC: begin
        alu_en    = 1'b1;
        alusrc    = (op_q == OP_R) ? SRC_REG : SRC_IMM;
        state_nxt = (op_q == OP_LUI) ? SHIFT : WB;
      end
      SHIFT: begin
        alu_en    = 1'b1;
        shift_en  = 1'b1;
        alusrc    = SRC_K16;
        state_nxt = WB;
      end
      WB: begin
        result_we = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A stall holds the state but keeps alusrc at its decoded value.
    if (stall_i) begin
      state_nxt = state;
      alu_en    = 1'b0;
      shift_en  = 1'b0;
      result_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      op_count <= 16'h0000;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= accept && (req_op == OP_ILL);
      if (accept)
        op_q <= req_op;
      if ((state == WB) && !stall_i)
        op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: per-cycle expected output vectors are queued
// as stimulus is driven and compared one cycle later.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic        req_ready;
  logic [1:0]  alusrc;
  logic        alu_en;
  logic        shift_en;
  logic        result_we;
  logic        err;
  logic [15:0] op_count;
`ifdef ALU_SEQ_STALL_EN
  logic        stall = 1'b0;
`endif

  int          checks = 0;
  int          passed = 0;
  logic [15:0] cnt = 16'h0000;
  logic [22:0] exp_q [$];

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ALU_SEQ_STALL_EN
    .stall     (stall),
`endif
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .alusrc    (alusrc),
    .alu_en    (alu_en),
    .shift_en  (shift_en),
    .result_we (result_we),
    .err       (err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Vector layout: {alusrc, alu_en, shift_en, result_we, err, req_ready, op_count}
  function automatic logic [22:0] v(input logic [1:0] src, input logic en, input logic sh,
                                    input logic we, input logic er, input logic rdy,
                                    input logic [15:0] c);
    return {src, en, sh, we, er, rdy, c};
  endfunction

  function automatic logic [22:0] obs();
    return {alusrc, alu_en, shift_en, result_we, err, req_ready, op_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0]  stim [2];
    logic [22:0] ev [2];
    logic [22:0] e, o;
    stim = '{4'b1000, 4'b0000};
    ev   = '{v(2'b00,0,0,0,0,1,16'h0), v(2'b00,0,0,0,0,1,16'h0)};
    for (int i = 0; i < 2; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL reset step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = 16'h0000;
  endtask

  task automatic test_rtype();
    logic [3:0]  stim [3];
    logic [22:0] ev [3];
    logic [22:0] e, o;
    stim = '{4'b0100, 4'b0000, 4'b0000};
    ev   = '{v(2'b00,1,0,0,0,0,cnt), v(2'b00,0,0,1,0,0,cnt), v(2'b00,0,0,0,0,1,cnt+16'd1)};
    for (int i = 0; i < 3; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL rtype step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = cnt + 16'd1;
  endtask

  task automatic test_lui();
    logic [3:0]  stim [4];
    logic [22:0] ev [4];
    logic [22:0] e, o;
    stim = '{4'b0110, 4'b0000, 4'b0000, 4'b0000};
    ev   = '{v(2'b01,1,0,0,0,0,cnt), v(2'b10,1,1,0,0,0,cnt),
             v(2'b00,0,0,1,0,0,cnt), v(2'b00,0,0,0,0,1,cnt+16'd1)};
    for (int i = 0; i < 4; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL lui step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = cnt + 16'd1;
  endtask

  task automatic test_illegal();
    logic [3:0]  stim [3];
    logic [22:0] ev [3];
    logic [22:0] e, o;
    stim = '{4'b0111, 4'b0000, 4'b0000};
    ev   = '{v(2'b00,0,0,0,1,1,cnt), v(2'b00,0,0,0,0,1,cnt), v(2'b00,0,0,0,0,1,cnt)};
    for (int i = 0; i < 3; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL illegal step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  stim [6];
    logic [22:0] ev [6];
    logic [22:0] e, o;
    stim = '{4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ev   = '{v(2'b01,1,0,0,0,0,cnt),        v(2'b00,0,0,1,0,0,cnt),
             v(2'b00,0,0,0,0,1,cnt+16'd1),  v(2'b00,1,0,0,0,0,cnt+16'd1),
             v(2'b00,0,0,1,0,0,cnt+16'd1),  v(2'b00,0,0,0,0,1,cnt+16'd2)};
    for (int i = 0; i < 6; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL b2b step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = cnt + 16'd2;
  endtask

  task automatic test_reset_mid_op();
    logic [3:0]  stim [4];
    logic [22:0] ev [4];
    logic [22:0] e, o;
    stim = '{4'b0110, 4'b0010, 4'b1000, 4'b0000};
    ev   = '{v(2'b01,1,0,0,0,0,cnt), v(2'b10,1,1,0,0,0,cnt),
             v(2'b00,0,0,0,0,1,16'h0), v(2'b00,0,0,0,0,1,16'h0)};
    for (int i = 0; i < 4; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL rst_mid step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = 16'h0000;
  endtask

  task automatic test_wrap();
    logic [3:0]  stim [3];
    logic [22:0] ev [3];
    logic [22:0] e, o;
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    cnt  = 16'hFFFF;
    stim = '{4'b0100, 4'b0000, 4'b0000};
    ev   = '{v(2'b00,1,0,0,0,0,16'hFFFF), v(2'b00,0,0,1,0,0,16'hFFFF),
             v(2'b00,0,0,0,0,1,16'h0000)};
    for (int i = 0; i < 3; i++) begin
      {rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL wrap step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = 16'h0000;
  endtask

`ifdef ALU_SEQ_STALL_EN
  task automatic test_stall();
    logic [4:0]  stim [6];
    logic [22:0] ev [6];
    logic [22:0] e, o;
    // {stall, rst, valid, op}
    stim = '{5'b00101, 5'b10000, 5'b10000, 5'b10000, 5'b00000, 5'b00000};
    ev   = '{v(2'b01,1,0,0,0,0,cnt), v(2'b01,0,0,0,0,0,cnt), v(2'b01,0,0,0,0,0,cnt),
             v(2'b01,0,0,0,0,0,cnt), v(2'b00,0,0,1,0,0,cnt), v(2'b00,0,0,0,0,1,cnt+16'd1)};
    for (int i = 0; i < 6; i++) begin
      {stall, rst, req_valid, req_op} = stim[i];
      exp_q.push_back(ev[i]);
      tick();
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) $display("[TB] FAIL stall step%0d got=%h exp=%h", i, o, e);
      else passed++;
    end
    cnt = cnt + 16'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_lui();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    test_wrap();
`ifdef ALU_SEQ_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
